button_event_capture: RTL and testbench

//  Input-side counterpart of the LED status output. Conditions one asynchronous push-button

---
 rtl/btn_evt_pkg.sv | 19 +
 rtl/event_fifo.sv | 55 +++++
 rtl/button_event_capture.sv | 143 ++++++++++++++
 tb/tb_button_event_capture.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the push-button event path: queued event record and debounce FSM states.
package btn_evt_pkg;

  // Widest timestamp an event record can carry; narrower counters are zero-extended.
  localparam int unsigned TS_W_MAX = 32;

  typedef struct packed {
    logic [TS_W_MAX-1:0] ts;
    logic                long_press;
  } btn_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_REL
  } btn_state_e;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO of button events; head reads as zero while empty.
module event_fifo
  import btn_evt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  btn_evt_t push_data_i,
  output logic     full_o,
  input  logic     pop_i,
  output logic     empty_o,
  output btn_evt_t head_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  btn_evt_t        mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/button_event_capture.sv
// Synchronizes and debounces one push-button, classifies each accepted press as
// short/long and queues a timestamped event for a valid/ready consumer.
module button_event_capture
  import btn_evt_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] LONG_CYCLES     = 24'd5000000,
  parameter int unsigned TS_W            = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [TS_W-1:0] evt_ts,
  output logic            evt_long,
  output logic            btn_level,
  output logic            overflow
);

  logic            sync1_q, sync2_q;
  logic            btn_s;
  logic [TS_W-1:0] ts_q, ts_d;
  btn_state_e      state_q;
  logic [15:0]     db_cnt_q;
  logic [23:0]     hold_cnt_q;
  logic [TS_W-1:0] press_ts_q;
  logic            btn_level_q;
  logic            overflow_q, overflow_d;
  logic            db_done, hold_sat;
  logic            evt_push, fifo_full, fifo_empty, fifo_pop;
  btn_evt_t        evt_new, fifo_head, unused_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign db_done  = (db_cnt_q == DEBOUNCE_CYCLES - 16'd1);
  assign hold_sat = (hold_cnt_q == LONG_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      press_ts_q  <= '0;
      btn_level_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q  <= DB_PRESS;
            db_cnt_q <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (db_done) begin
            state_q     <= HELD;
            press_ts_q  <= ts_q;
            hold_cnt_q  <= '0;
            btn_level_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 16'd1;
          end
        end
        HELD: begin
          if (!hold_sat) hold_cnt_q <= hold_cnt_q + 24'd1;
          if (!btn_s) begin
            state_q  <= DB_REL;
            db_cnt_q <= '0;
          end
        end
        DB_REL: begin
          // Hold time keeps accruing through release bounce so a bounced press is one press.
          if (!hold_sat) hold_cnt_q <= hold_cnt_q + 24'd1;
          if (btn_s) begin
            state_q <= HELD;
          end else if (db_done) begin
            state_q     <= IDLE;
            btn_level_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_push           = (state_q == DB_REL) && !btn_s && db_done;
  assign evt_new.ts         = TS_W_MAX'(press_ts_q);
  assign evt_new.long_press = (hold_cnt_q >= LONG_CYCLES);

  assign fifo_pop = !fifo_empty && evt_ready;

  event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (evt_push),
    .push_data_i (evt_new),
    .full_o      (fifo_full),
    .pop_i       (fifo_pop),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign overflow_d = overflow_q | (evt_push && fifo_full && !fifo_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  // Timestamp bits above TS_W are always zero in the queued record.
  assign unused_head = fifo_head;

  assign evt_valid = !fifo_empty;
  assign evt_ts    = fifo_head.ts[TS_W-1:0];
  assign evt_long  = fifo_head.long_press;
  assign btn_level = btn_level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_capture.sv
// Randomized self-checking bench for button_event_capture against a run-length/queue model.
module tb_button_event_capture;

  localparam int D     = 4;
  localparam int L     = 16;
  localparam int TSW   = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           btn_in;
  logic           evt_ready;
  logic           evt_valid;
  logic [TSW-1:0] evt_ts;
  logic           evt_long;
  logic           btn_level;
  logic           overflow;
  logic [11:0]    dut_vec;

  int compared   = 0;
  int mismatched = 0;

  button_event_capture #(
    .DEBOUNCE_CYCLES (16'd4),
    .LONG_CYCLES     (24'd16),
    .TS_W            (TSW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ts    (evt_ts),
    .evt_long  (evt_long),
    .btn_level (btn_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign dut_vec = {evt_valid, evt_ts, evt_long, btn_level, overflow};

  // Reference model: level flips after D+1 consecutive opposite synchronized samples;
  // long = cycles spent accepted-high minus one, compared against L.
  typedef struct {
    int ts;
    bit lng;
  } ev_t;

  ev_t q[$];
  bit  h1, h2, m_lvl, m_ovf;
  bit  m_s, m_have_ev;
  int  m_run, m_cyc, m_hold_start, m_press_ts, m_ts;
  ev_t m_ev;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        h1 = 0; h2 = 0; m_lvl = 0; m_ovf = 0;
        m_run = 0; m_cyc = 0; m_ts = 0; m_hold_start = 0; m_press_ts = 0;
        q.delete();
      end else begin
        m_s = h2; h2 = h1; h1 = btn_in;
        m_have_ev = 0;
        if (m_s != m_lvl) begin
          m_run++;
          if (m_run == D + 1) begin
            m_run = 0;
            m_lvl = m_s;
            if (m_s) begin
              m_hold_start = m_cyc;
              m_press_ts   = m_ts;
            end else begin
              m_have_ev = 1;
              m_ev.ts   = m_press_ts;
              m_ev.lng  = (m_cyc - m_hold_start - 1) >= L;
            end
          end
        end else begin
          m_run = 0;
        end
        if (q.size() > 0 && evt_ready) void'(q.pop_front());
        if (m_have_ev) begin
          if (q.size() < DEPTH) q.push_back(m_ev);
          else m_ovf = 1;
        end
        m_ts = (m_ts + 1) % 256;
        m_cyc++;
      end
    end
  end

  function automatic logic [11:0] exp_vec();
    logic [7:0] t;
    if (q.size() > 0) begin
      t = 8'(q[0].ts);
      return {1'b1, t, q[0].lng, m_lvl, m_ovf};
    end
    return {1'b0, 8'h00, 1'b0, m_lvl, m_ovf};
  endfunction

  function automatic bit m_accept_next();
    return m_lvl && !h2 && (m_run == D);
  endfunction

  bit pat[$];

  function automatic void add_seg(bit lvl, int n);
    repeat (n) pat.push_back(lvl);
  endfunction

  task automatic test_reset();
    rst = 0; btn_in = 0; evt_ready = 0;
    #1 rst = 1;
    #1;
    compared++;
    if (dut_vec !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_async got=%h exp=%h", dut_vec, 12'h000);
    end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    compared++;
    if (dut_vec !== 12'h000 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec, 12'h000);
    end
  endtask

  task automatic test_clean_press();
    int n_evt = 0; bit seen_lvl = 0; bit lng = 1;
    pat.delete(); add_seg(1, 10); add_seg(0, 25);
    evt_ready = 1;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL clean_press c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (btn_level) seen_lvl = 1;
      if (evt_valid && evt_ready) begin n_evt++; lng = evt_long; end
    end
    compared++;
    if (n_evt !== 1 || lng !== 1'b0 || seen_lvl !== 1'b1) begin
      mismatched++;
      $display("FAIL clean_press_summary events=%0d long=%0d level_seen=%0d exp 1/0/1", n_evt, lng, seen_lvl);
    end
  endtask

  task automatic test_glitch();
    bit seen = 0;
    pat.delete(); add_seg(1, 3); add_seg(0, 15); add_seg(1, 4); add_seg(0, 15);
    evt_ready = 1;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL glitch c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (c < 18 && (btn_level || evt_valid)) seen = 1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_3cyc level_or_valid_seen=%0d exp 0", seen);
    end
  endtask

  task automatic test_long_press();
    bit longs[$];
    pat.delete();
    add_seg(1, 20);  add_seg(0, 25);
    add_seg(1, 200); add_seg(0, 25);
    add_seg(1, 16);  add_seg(0, 25);
    add_seg(1, 17);  add_seg(0, 25);
    evt_ready = 1;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL long_press c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (evt_valid && evt_ready) longs.push_back(evt_long);
    end
    compared++;
    if (longs.size() != 4 || longs[0] !== 1'b1 || longs[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL long_press_flags events=%0d first=%0d second=%0d exp 4/1/1",
               longs.size(), longs.size() > 0 ? longs[0] : 1'b0, longs.size() > 1 ? longs[1] : 1'b0);
    end
  endtask

  task automatic test_release_bounce();
    int n_evt = 0; bit lng = 1;
    pat.delete(); add_seg(1, 10); add_seg(0, 2); add_seg(1, 1); add_seg(0, 30);
    evt_ready = 1;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL release_bounce c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (evt_valid && evt_ready) begin n_evt++; lng = evt_long; end
    end
    compared++;
    if (n_evt !== 1 || lng !== 1'b0) begin
      mismatched++;
      $display("FAIL release_bounce_summary events=%0d long=%0d exp 1/0", n_evt, lng);
    end
  endtask

  task automatic test_push_pop_full();
    bit hit = 0;
    pat.delete();
    repeat (4) begin add_seg(1, 8); add_seg(0, 12); end
    evt_ready = 0;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL push_pop_fill c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    for (int c = 0; c < 40; c++) begin
      btn_in    = (c < 8);
      evt_ready = m_accept_next();
      if (evt_ready) hit = 1;
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL push_pop_full c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    compared++;
    if (!hit || overflow !== 1'b0 || evt_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL push_pop_full_summary aligned=%0d overflow=%0d valid=%0d exp 1/0/1", hit, overflow, evt_valid);
    end
    evt_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL push_pop_drain c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ts_list[$];
    pat.delete();
    repeat (5) begin add_seg(1, 8); add_seg(0, 12); end
    add_seg(0, 10);
    evt_ready = 0;
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    compared++;
    if (overflow !== 1'b1 || evt_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure_overflow overflow=%0d valid=%0d exp 1/1", overflow, evt_valid);
    end
    evt_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (evt_valid) ts_list.push_back(evt_ts);
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL backpressure_drain c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    compared++;
    if (ts_list.size() != 4 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure_drain_count drained=%0d overflow=%0d exp 4/1", ts_list.size(), overflow);
    end
    for (int i = 0; i + 1 < ts_list.size(); i++) begin
      compared++;
      if (8'(ts_list[i+1] - ts_list[i]) !== 8'd20) begin
        mismatched++;
        $display("FAIL backpressure_order i=%0d ts=%0d next=%0d exp step 20", i, ts_list[i], ts_list[i+1]);
      end
    end
  endtask

  task automatic test_reset_held();
    bit seen = 0;
    evt_ready = 0;
    pat.delete(); add_seg(1, 8); add_seg(0, 14); add_seg(1, 10);
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL reset_held_pre c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    compared++;
    if (btn_level !== 1'b1 || evt_valid !== 1'b1 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_held_setup level=%0d valid=%0d overflow=%0d exp 1/1/1", btn_level, evt_valid, overflow);
    end
    #2 rst = 1;
    #1;
    compared++;
    if (dut_vec !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_held_async got=%h exp=%h", dut_vec, 12'h000);
    end
    @(negedge clk);
    rst = 0;
    evt_ready = 1;
    pat.delete(); add_seg(1, 2); add_seg(0, 30);
    foreach (pat[c]) begin
      btn_in = pat[c];
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL reset_held_post c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (evt_valid || btn_level || overflow) seen = 1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_held_no_event activity_seen=%0d exp 0", seen);
    end
  endtask

  task automatic test_random();
    int remain = 0;
    bit lvl = 0;
    for (int c = 0; c < 1500; c++) begin
      if (remain == 0) begin
        lvl    = !lvl;
        remain = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 8);
      end
      remain--;
      btn_in = lvl;
      if ((c % 300) < 100) evt_ready = 0;
      else evt_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_push_pop_full();
    test_back_to_back();
    test_reset_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
